// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM states and default width.
package mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_sign_unit.sv
// Sign handling around an unsigned core: operand magnitudes on entry and
// conditional two's-complement negation of the finished product.
module mult_sign_unit #(
  parameter int WIDTH = 8
) (
  input  logic               sgn,
  input  logic [WIDTH-1:0]   mlt,
  input  logic [WIDTH-1:0]   mcd,
  output logic [WIDTH-1:0]   mlt_mag,
  output logic [WIDTH-1:0]   mcd_mag,
  output logic               neg,
  input  logic               fix_neg,
  input  logic [2*WIDTH-1:0] raw,
  output logic [2*WIDTH-1:0] fixed
);

  // Negating the most-negative value wraps to itself, which read as unsigned
  // is exactly its magnitude 2^(WIDTH-1).
  assign mlt_mag = (sgn && mlt[WIDTH-1]) ? -mlt : mlt;
  assign mcd_mag = (sgn && mcd[WIDTH-1]) ? -mcd : mcd;
  assign neg     = sgn && (mlt[WIDTH-1] ^ mcd[WIDTH-1]);

  assign fixed   = fix_neg ? -raw : raw;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, fixed latency,
// unsigned or two's-complement operands.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   mlt,
  input  logic [WIDTH-1:0]   mcd,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  state_t               state, nxt;
  logic [2*WIDTH:0]     acc;
  logic [WIDTH-1:0]     mcd_q;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 busy_d, done_d;

  logic [WIDTH-1:0]     mlt_mag, mcd_mag;
  logic                 neg_in;
  logic [2*WIDTH-1:0]   fixed;
  logic [WIDTH:0]       sum;
  logic                 last;

  mult_sign_unit #(.WIDTH(WIDTH)) u_sign (
    .sgn     (sgn),
    .mlt     (mlt),
    .mcd     (mcd),
    .mlt_mag (mlt_mag),
    .mcd_mag (mcd_mag),
    .neg     (neg_in),
    .fix_neg (neg),
    .raw     (acc[2*WIDTH-1:0]),
    .fixed   (fixed)
  );

  // Upper half is below 2^WIDTH after every shift, so WIDTH+1 bits hold the carry.
  assign sum  = acc[2*WIDTH:WIDTH] + {1'b0, mcd_q};
  assign last = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (st) nxt = CALC;
      CALC:    if (last) nxt = FIX;
      FIX:     nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state == CALC) || (state == FIX);
    done_d = (state == DONE);
  end

  // Status outputs are registered, so they trail the state by one cycle:
  // done rises while the FSM is already back in IDLE and ready for st.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcd_q <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: if (st) begin
          acc   <= {{(WIDTH+1){1'b0}}, mlt_mag};
          mcd_q <= mcd_mag;
          neg   <= neg_in;
          cnt   <= '0;
        end
        CALC: begin
          acc <= acc[0] ? {1'b0, sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};
          cnt <= cnt + CNT_W'(1);
        end
        FIX:     prod <= fixed;
        default: ;
      endcase
    end
  end

endmodule
